// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the data-memory responder.
// Misaligned-access checking is enabled in the top with DMEM_ALIGN_CHECK_EN.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Byte-lane write enables; size 2'b11 falls through to word.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << off;
      SZ_HALF: lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Replicate narrow store data so every enabled lane sees its byte.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: lane_data = {4{data[7:0]}};
      SZ_HALF: lane_data = {2{data[15:0]}};
      default: lane_data = data;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [31:0] shifted;
    shifted = word;
    case (size)
      SZ_BYTE: begin
        shifted      = word >> {off, 3'b000};
        load_extract = {24'h0, shifted[7:0]};
      end
      SZ_HALF: begin
        shifted      = word >> {off[1], 4'b0000};
        load_extract = {16'h0, shifted[15:0]};
      end
      default: load_extract = shifted;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = off[0];
      default: misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-enabled word storage: one asynchronous read port, one synchronous write port.
module dmem_array #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem_q[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed wait-state insertion.
// Define DMEM_ALIGN_CHECK_EN to add the derr port and misaligned-access suppression.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dreq,
  input  logic        dwrite,
  input  logic [31:0] daddr,
  input  logic [1:0]  dsize,
  inout  wire  [31:0] ddata,
  output logic        dbusy,
  output logic        dready_n
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic        derr
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          write_q, write_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          resp;
  logic          access_ok;
  logic          commit;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [31:0]   load_data;

  // Addresses wrap modulo the store size; bits above the word index are dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^daddr[31:AW+2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= SZ_WORD;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (dreq) begin
          write_d = dwrite;
          addr_d  = daddr[AW+1:0];
          size_d  = dsize;
          if (dwrite) wdata_d = ddata;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign access_ok = !misaligned(size_d, addr_d[1:0]);
`else
  assign access_ok = 1'b1;
`endif

  // The *_d view equals the live request when WAIT_CYCLES is 0, so one path serves both.
  assign commit    = (state_d == S_RESP) && write_d && access_ok && !rst;
  assign mem_be    = commit ? lane_mask(size_d, addr_d[1:0]) : 4'b0000;
  assign mem_wdata = lane_data(size_d, wdata_d);

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .we   (mem_be),
    .waddr(addr_d[AW+1:2]),
    .wdata(mem_wdata),
    .raddr(addr_q[AW+1:2]),
    .rdata(mem_rdata)
  );

  assign resp = (state_q == S_RESP);

`ifdef DMEM_ALIGN_CHECK_EN
  assign load_data = misaligned(size_q, addr_q[1:0]) ? 32'h0
                                                     : load_extract(size_q, addr_q[1:0], mem_rdata);
  assign derr      = resp && misaligned(size_q, addr_q[1:0]);
`else
  assign load_data = load_extract(size_q, addr_q[1:0], mem_rdata);
`endif

  assign dbusy    = (state_q == S_WAIT);
  assign dready_n = !resp;
  assign ddata    = (resp && !write_q) ? load_data : 32'hz;

endmodule
